// File: rtl/divm_meter_pkg.sv
// Shared types and defaults for the divided-clock meter.
package divm_meter_pkg;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 65535;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    LOST    = 2'd3
  } state_e;

endpackage

// File: rtl/divm_meter_if.sv
// Measurement result bundle: edge strobes, period/high-time, valid and loss flag.
interface divm_meter_if #(
  parameter int unsigned CNT_W = divm_meter_pkg::CNT_W_DEF
);

  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             lost;

  modport master (
    output rise_pulse,
    output fall_pulse,
    output period,
    output high_time,
    output valid,
    output lost
  );

  modport slave (
    input rise_pulse,
    input fall_pulse,
    input period,
    input high_time,
    input valid,
    input lost
  );

endinterface

// File: rtl/divm_meter_sync2.sv
// Two-flop synchroniser, asynchronous active-low reset to 0.
module sync2 (
  input  logic clk_in,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/divm_meter.sv
// Period / high-time meter for an asynchronous divided clock, with loss detection.
// Optional glitch filter enabled by defining DIVM_METER_FILTER_EN.
module divm_meter
  import divm_meter_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic         sig_in,
  divm_meter_if.master mon
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

  logic sync_lvl;
  logic lvl;
  logic hist_q;
  logic rise_det;
  logic fall_det;

  sync2 u_sync (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .d_i     (sig_in),
    .q_o     (sync_lvl)
  );

`ifdef DIVM_METER_FILTER_EN
  logic prev_q;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync_lvl;
    end
  end

  // The history flop doubles as the filter's held level: the level only
  // follows the synchroniser once two consecutive samples agree.
  assign lvl = (sync_lvl == prev_q) ? sync_lvl : hist_q;
`else
  assign lvl = sync_lvl;
`endif

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= lvl;
    end
  end

  assign rise_det = lvl & ~hist_q;
  assign fall_det = ~lvl & hist_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] pcnt_inc;
  logic [CNT_W-1:0] hcnt_inc;

  always_comb begin
    pcnt_inc = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + CNT_ONE;
    hcnt_inc = hcnt_q;
    if (lvl && (hcnt_q != CNT_MAX)) begin
      hcnt_inc = hcnt_q + CNT_ONE;
    end
  end

  // Decisions are taken on the unregistered edge detect so that the loaded
  // results, valid and the rise strobe all become visible in the same cycle.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    hcnt_d  = hcnt_q;
    per_d   = per_q;
    high_d  = high_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE, LOST: begin
        if (rise_det) begin
          state_d = ARMED;
          pcnt_d  = CNT_ONE;
          hcnt_d  = CNT_ONE;
        end
      end
      ARMED, MEASURE: begin
        if (rise_det) begin
          state_d = MEASURE;
          per_d   = pcnt_q;
          high_d  = hcnt_q;
          valid_d = 1'b1;
          pcnt_d  = CNT_ONE;
          hcnt_d  = CNT_ONE;
        end else if (pcnt_q >= TMO) begin
          state_d = LOST;
        end else begin
          pcnt_d = pcnt_inc;
          hcnt_d = hcnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
      per_q   <= '0;
      high_q  <= '0;
      valid_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
      per_q   <= per_d;
      high_q  <= high_d;
      valid_q <= valid_d;
      rise_q  <= rise_det;
      fall_q  <= fall_det;
    end
  end

  assign mon.rise_pulse = rise_q;
  assign mon.fall_pulse = fall_q;
  assign mon.period     = per_q;
  assign mon.high_time  = high_q;
  assign mon.valid      = valid_q;
  assign mon.lost       = (state_q == LOST);

endmodule
